dl_sequencer: RTL and testbench
===============================

DL_SEQUENCER -- requirements
Module: dl_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, meaning clk_sys cycles core_reset stays high after the last download ends.
REQ-002 SHALL have parameter ROM_LIMIT, default 16'hFFFF, meaning the highest ROM address accepted; writes above it are dropped.
REQ-003 SHALL have port clk_sys, input, 1, the only clock.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports ioctl_download, ioctl_wr, input, 1 each, the HPS download strobes.
REQ-006 SHALL have ports ioctl_addr (input, 25), ioctl_dout (input, 8) and ioctl_index (input, 8), carrying the download address, data and target index.
REQ-007 SHALL have port ioctl_wait, output, 1, which stalls HPS writes.
REQ-008 SHALL have ports rom_wr (output, 1), rom_addr (output, 16) and rom_data (output, 8), the ROM write port.
REQ-009 SHALL have port rom_ready, input, 1, which is high when the ROM sink accepts a write this cycle.
REQ-010 SHALL have port core_reset, output, 1, high while the game core is held in reset.
REQ-011 SHALL have ports mod_id (output, 8) and mod_valid (output, 1), the selected game variant.
REQ-012 SHALL have port dip (output, 8 bytes, unpacked [8]), the DIP bank.

Function
REQ-013 States SHALL be IDLE, ROM, CFG, HOLD and RUN; the reset state is IDLE.
REQ-014 In IDLE or RUN, ioctl_download=1 with index 0 or 1 SHALL go to ROM or CFG respectively on the next cycle and set core_reset=1.
REQ-015 Index 254 downloads SHALL not change state or core_reset.
REQ-016 In ROM, when ioctl_wr=1 and ioctl_addr<=ROM_LIMIT, the byte SHALL be captured into a one-entry buffer.
REQ-017 The ROM buffer SHALL present rom_wr=1 with the buffered addr/data from the next cycle until a cycle with rom_ready=1; that cycle completes the write.
REQ-018 ioctl_wait SHALL be 1 whenever the buffer is full, and 0 otherwise.
REQ-019 When ioctl_wr=1 arrives on the same cycle the buffer drains, the new byte SHALL be accepted with no bubble.
REQ-020 ROM writes with ioctl_addr>ROM_LIMIT SHALL be discarded, SHALL not assert ioctl_wait, and SHALL not occupy the buffer.
REQ-021 In CFG, each ioctl_wr SHALL latch ioctl_dout into mod_id, so the last byte wins.
REQ-022 mod_valid SHALL be set on the first CFG write and cleared only by reset.
REQ-023 With index 254, ioctl_wr=1 and ioctl_addr[24:3]=0, the byte SHALL be written to dip[ioctl_addr[2:0]] in any state.
REQ-024 Index 254 writes at higher addresses SHALL be ignored.
REQ-025 When ioctl_download falls in ROM or CFG, the FSM SHALL go to HOLD, but only after the ROM buffer is empty.
REQ-026 In HOLD, a counter SHALL load HOLD_CYCLES-1 on entry and decrement every cycle; at 0 the FSM SHALL go to RUN and clear core_reset on that same edge.
REQ-027 ioctl_download rising while in HOLD SHALL abort the hold and re-enter ROM or CFG; the counter SHALL reload on the next HOLD entry.
REQ-028 Within ROM/CFG, the captured ioctl_index SHALL be held; a mid-download index change SHALL be ignored until download falls.
REQ-029 HOLD_CYCLES=1 SHALL give exactly one cycle in HOLD.

Reset
REQ-030 On reset_n=0 at a clk_sys edge, reset values SHALL be: state IDLE, core_reset=1, rom_wr=0, rom_addr=0, rom_data=0, ioctl_wait=0, buffer empty, mod_id=0, mod_valid=0, all dip bytes 8'hFF, counter 0.
REQ-031 IDLE SHALL go to HOLD unconditionally when ioctl_download=0, so the core leaves reset HOLD_CYCLES after reset release.
REQ-032 Reset asserted mid-download SHALL drop the buffered byte, and no rom_wr SHALL follow.

Configuration
REQ-033 With macro DL_SEQUENCER_CHECKSUM_EN defined, output rom_sum (16) SHALL clear on ROM entry and add each byte completed per REQ-017, mod 2^16.
REQ-034 rom_sum SHALL be valid in HOLD/RUN.
REQ-035 Without DL_SEQUENCER_CHECKSUM_EN, the rom_sum port and adder SHALL be absent; all other behaviour is identical.

Structure
REQ-036 Package dl_pkg SHALL hold the state enum and the index constants IDX_ROM=0, IDX_MOD=1 and IDX_DIP=254.
REQ-037 Sub-module dl_hold_timer (load/decrement/zero flag) SHALL implement the HOLD counter; everything else is flat.

Verification
REQ-038 Release reset with download=0 -> core_reset=1 for exactly 16 cycles after release, then 0; dip all 8'hFF.
REQ-039 ROM download of 4 bytes at addr 0..3, data A5,5A,00,FF, rom_ready=1 -> four rom_wr pulses with matching addr/data one cycle after each ioctl_wr; rom_sum=16'h01FE.
REQ-040 rom_ready=0 for 5 cycles during a 2-byte back-to-back burst -> ioctl_wait=1 until drain, no byte lost or duplicated, addresses in order.
REQ-041 CFG download of 8'h0C -> mod_id=8'h0C, mod_valid=1; core_reset falls 16 cycles after download falls.
REQ-042 Index 254 writes at addr 2 (8'h3C) and at addr 9 (8'h11) -> dip[2]=8'h3C, all other dip bytes 8'hFF.
REQ-043 New download rises 3 cycles into HOLD -> core_reset stays 1 and a full 16-cycle hold follows the second download.

Source files
------------

// File: rtl/dl_pkg.sv
// Shared types and constants for the HPS download sequencer.
package dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM,
    ST_CFG,
    ST_HOLD,
    ST_RUN
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/dl_hold_timer.sv
// Post-download hold counter: loads HOLD_CYCLES-1, counts down, flags zero.
module dl_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= CW'(HOLD_CYCLES - 1);
    else if (dec && (cnt != '0))
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dl_sequencer.sv
// HPS download sequencer: ROM write buffer, variant select, DIP bank, core reset hold.
// Optional rom_sum byte checksum output is enabled by DL_SEQUENCER_CHECKSUM_EN.
module dl_sequencer
  import dl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] ROM_LIMIT   = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic        core_reset,
  output logic [7:0]  mod_id,
  output logic        mod_valid,
`ifdef DL_SEQUENCER_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic [7:0]  dip [8]
);

  dl_state_t state, state_nxt;
  logic      core_nxt;
  logic      buf_full;
  logic      capture, drain;
  logic      hold_load, hold_dec, hold_zero;
  logic      dip_hit;

  always_comb begin
    state_nxt = state;
    core_nxt  = core_reset;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (ioctl_download && ioctl_index == IDX_ROM) begin
          state_nxt = ST_ROM;
          core_nxt  = 1'b1;
        end else if (ioctl_download && ioctl_index == IDX_MOD) begin
          state_nxt = ST_CFG;
          core_nxt  = 1'b1;
        end else if (!ioctl_download && state == ST_IDLE) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_ROM:  if (!ioctl_download && !buf_full) state_nxt = ST_HOLD;
      ST_CFG:  if (!ioctl_download) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (ioctl_download && ioctl_index == IDX_ROM) begin
          state_nxt = ST_ROM;
        end else if (ioctl_download && ioctl_index == IDX_MOD) begin
          state_nxt = ST_CFG;
        end else if (hold_zero) begin
          state_nxt = ST_RUN;
          core_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign hold_load = (state_nxt == ST_HOLD) && (state != ST_HOLD);
  assign hold_dec  = (state == ST_HOLD);

  dl_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (hold_load),
    .dec     (hold_dec),
    .zero    (hold_zero)
  );

  // A new byte may enter on the same cycle the previous one drains.
  assign drain   = buf_full && rom_ready;
  assign capture = (state == ST_ROM) && ioctl_wr &&
                   (ioctl_addr <= {9'd0, ROM_LIMIT}) && (!buf_full || rom_ready);
  assign dip_hit = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      core_reset <= 1'b1;
      buf_full   <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      mod_id     <= '0;
      mod_valid  <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) dip[i] <= '1;
    end else begin
      state      <= state_nxt;
      core_reset <= core_nxt;
      buf_full   <= capture || (buf_full && !rom_ready);
      if (capture) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
      if (state == ST_CFG && ioctl_wr) begin
        mod_id    <= ioctl_dout;
        mod_valid <= 1'b1;
      end
      if (dip_hit) dip[ioctl_addr[2:0]] <= ioctl_dout;
    end
  end

  assign rom_wr     = buf_full;
  assign ioctl_wait = buf_full;

`ifdef DL_SEQUENCER_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      rom_sum <= '0;
    else if (state_nxt == ST_ROM && state != ST_ROM)
      rom_sum <= '0;
    else if (drain)
      rom_sum <= rom_sum + {8'h00, rom_data};
  end
`endif

endmodule

// File: tb/tb_dl_sequencer.sv
// Directed self-checking bench for dl_sequencer (default and HOLD_CYCLES=1 builds).
module tb_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        rom_ready;
  logic        ioctl_wait, rom_wr, core_reset, mod_valid;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, mod_id;
  logic [7:0]  dip [8];
  logic        ioctl_wait1, rom_wr1, core_reset1, mod_valid1;
  logic [15:0] rom_addr1;
  logic [7:0]  rom_data1, mod_id1;
  logic [7:0]  dip1 [8];
`ifdef DL_SEQUENCER_CHECKSUM_EN
  logic [15:0] rom_sum, rom_sum1;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] done_q[$];

  always #5 clk_sys = ~clk_sys;

  dl_sequencer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .rom_wr(rom_wr),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
    .core_reset(core_reset), .mod_id(mod_id), .mod_valid(mod_valid),
`ifdef DL_SEQUENCER_CHECKSUM_EN
    .rom_sum(rom_sum),
`endif
    .dip(dip)
  );

  dl_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait1), .rom_wr(rom_wr1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .rom_ready(rom_ready),
    .core_reset(core_reset1), .mod_id(mod_id1), .mod_valid(mod_valid1),
`ifdef DL_SEQUENCER_CHECKSUM_EN
    .rom_sum(rom_sum1),
`endif
    .dip(dip1)
  );

  // Record every completed ROM write (addr) as seen mid-cycle.
  always @(negedge clk_sys) if (rom_wr && rom_ready) done_q.push_back(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Cycles core_reset stays high from now until it falls (bounded).
  task automatic count_release(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!core_reset) break;
      n++;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int n0;
    logic [7:0] rom_vec [4];
    rom_vec = '{8'hA5, 8'h5A, 8'h00, 8'hFF};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0; rom_ready = 1'b1;
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_rom_wr", rom_wr, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_data", rom_data, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_mod_id", mod_id, 0);
    check("rst_mod_valid", mod_valid, 0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_dip%0d", i), dip[i], 8'hFF);

    // Release: both instances start counting; HOLD_CYCLES=1 leaves after two edges.
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) check("h1_hold_cycle", core_reset1, 1);
      if (i == 1) check("h1_released", core_reset1, 0);
      if (!core_reset) break;
      n++;
    end
    check("rst_hold_len", n, 16);

    // ROM download of four bytes, sink always ready.
    start_dl(8'd0);
    check("rom_enter_core_reset", core_reset, 1);
    for (int k = 0; k < 4; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = rom_vec[k];
      tick();
      check($sformatf("rom_wr_%0d", k), rom_wr, 1);
      check($sformatf("rom_addr_%0d", k), rom_addr, k);
      check($sformatf("rom_data_%0d", k), rom_data, rom_vec[k]);
    end
    ioctl_addr = 25'h10000; ioctl_dout = 8'h77;
    tick();
    check("drop_wait", ioctl_wait, 0);
    check("drop_rom_wr", rom_wr, 0);
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    count_release(n);
    check("rom_hold_len", n, 16);
`ifdef DL_SEQUENCER_CHECKSUM_EN
    check("rom_sum_4", rom_sum, 16'h01FE);
`endif

    // Back-to-back pair with the sink stalled for five cycles.
    start_dl(8'd0);
    n0 = done_q.size();
    rom_ready = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'h11;
    tick();
    check("stall_wait_on", ioctl_wait, 1);
    ioctl_addr = 25'h11; ioctl_dout = 8'h22;
    repeat (4) tick();
    check("stall_wait_held", ioctl_wait, 1);
    check("stall_addr_held", rom_addr, 16'h10);
    check("stall_data_held", rom_data, 8'h11);
    rom_ready = 1'b1;
    tick();
    check("stall_refill_addr", rom_addr, 16'h11);
    check("stall_refill_data", rom_data, 8'h22);
    check("stall_refill_wait", ioctl_wait, 1);
    ioctl_wr = 1'b0;
    tick();
    check("stall_drained_wait", ioctl_wait, 0);
    check("stall_drained_wr", rom_wr, 0);
    check("stall_count", done_q.size() - n0, 2);
    if (done_q.size() >= n0 + 2) begin
      check("stall_order0", done_q[n0], 16'h10);
      check("stall_order1", done_q[n0+1], 16'h11);
    end
    ioctl_download = 1'b0;
    count_release(n);
    check("stall_hold_len", n, 16);
`ifdef DL_SEQUENCER_CHECKSUM_EN
    check("rom_sum_2", rom_sum, 16'h0033);
`endif

    // CFG download: last byte wins.
    start_dl(8'd1);
    ioctl_wr = 1'b1; ioctl_addr = '0; ioctl_dout = 8'h07;
    tick();
    ioctl_dout = 8'h0C;
    tick();
    ioctl_wr = 1'b0;
    check("cfg_mod_id", mod_id, 8'h0C);
    check("cfg_mod_valid", mod_valid, 1);
    ioctl_download = 1'b0;
    count_release(n);
    check("cfg_hold_len", n, 16);

    // DIP writes from RUN; core must stay released.
    start_dl(8'd254);
    check("dip_no_core_reset", core_reset, 0);
    ioctl_wr = 1'b1; ioctl_addr = 25'd2; ioctl_dout = 8'h3C;
    tick();
    ioctl_addr = 25'd9; ioctl_dout = 8'h11;
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    check("dip_core_still_run", core_reset, 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("dip%0d", i), dip[i], (i == 2) ? 8'h3C : 8'hFF);

    // Re-download three cycles into HOLD aborts and restarts the hold.
    start_dl(8'd1);
    ioctl_download = 1'b0;
    repeat (3) tick();
    check("abort_in_hold", core_reset, 1);
    start_dl(8'd1);
    check("abort_core_reset", core_reset, 1);
    tick();
    check("abort_cfg_core_reset", core_reset, 1);
    ioctl_download = 1'b0;
    count_release(n);
    check("abort_hold_len", n, 16);

    // Reset in the middle of a stalled ROM write drops the byte.
    start_dl(8'd0);
    rom_ready = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 25'h55; ioctl_dout = 8'h99;
    tick();
    check("midrst_buffered", rom_wr, 1);
    reset_n = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    check("midrst_rom_wr", rom_wr, 0);
    check("midrst_wait", ioctl_wait, 0);
    check("midrst_core_reset", core_reset, 1);
    check("midrst_mod_valid", mod_valid, 0);
    check("midrst_mod_id", mod_id, 0);
    check("midrst_dip2", dip[2], 8'hFF);
    n0 = done_q.size();
    rom_ready = 1'b1;
    reset_n = 1'b1;
    count_release(n);
    check("midrst_hold_len", n, 16);
    check("midrst_no_write", done_q.size() - n0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
